// File: rtl/monster_array_controller_if.sv
// Monster array controller bus interface.
// Bundles every non-clock/reset signal of monster_array_controller.
//   master : drives VGA scan position, game state, bullet, scroll, spawn
//            column and score; receives pixel, live flags, hit and kill count
//   slave  : the controller side (mirror of master)
// N_MON must match the controller's N_MON (width of mon_alive).
interface monster_array_controller_if #(
  parameter int N_MON = 3
);
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [1:0]       state;
  logic [9:0]       blt_x;
  logic [9:0]       blt_y;
  logic             blt_exist;
  logic [3:0]       adv;
  logic [8:0]       rand_x;
  logic [13:0]      score;
  logic             valid;
  logic [16:0]      pixel_addr;
  logic [N_MON-1:0] mon_alive;
  logic             blt_hit;
  logic [7:0]       kill_cnt;

  modport master (
    output h_cnt, v_cnt, state, blt_x, blt_y, blt_exist, adv, rand_x, score,
    input  valid, pixel_addr, mon_alive, blt_hit, kill_cnt
  );

  modport slave (
    input  h_cnt, v_cnt, state, blt_x, blt_y, blt_exist, adv, rand_x, score,
    output valid, pixel_addr, mon_alive, blt_hit, kill_cnt
  );
endinterface

// File: rtl/monster_array_controller.sv
// Monster array controller.
// Manages N_MON monster slots: spawning on score milestones, horizontal
// bouncing, downward scrolling, bullet collision and sprite pixel lookup.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : monster_array_controller_if.slave (inputs h_cnt, v_cnt, state,
//          blt_x, blt_y, blt_exist, adv, rand_x, score; outputs valid,
//          pixel_addr, mon_alive, blt_hit, kill_cnt)
// Optional feature macro: MON_HP_EN (multi-hit monsters with a FLASH
// immunity state; adds HP_MAX and FLASH_CYC parameters).
module monster_array_controller #(
  parameter int N_MON     = 3,
  parameter int MON_W     = 120,
  parameter int MON_H     = 67,
  parameter int SPD_X     = 10,
  parameter int SPAWN_GAP = 500,
  parameter int MAP_W     = 640,
  parameter int MAP_H     = 480
`ifdef MON_HP_EN
  ,
  parameter int HP_MAX    = 2,
  parameter int FLASH_CYC = 8
`endif
) (
  input logic                      clk,
  input logic                      rst,
  monster_array_controller_if.slave bus
);

  localparam logic [10:0] MON_W11   = 11'(MON_W);
  localparam logic [10:0] MON_H11   = 11'(MON_H);
  localparam logic [10:0] RIGHT_LIM = 11'(MAP_W);
  localparam logic [10:0] W_PLUS_SP = 11'(MON_W + SPD_X);
  localparam logic [9:0]  SPD10     = 10'(SPD_X);
  localparam logic [9:0]  MAP_H10   = 10'(MAP_H);
  localparam logic [9:0]  X_MAX     = 10'(MAP_W - MON_W);
  localparam logic [14:0] GAP15     = 15'(SPAWN_GAP);

`ifdef MON_HP_EN
  localparam int HP_W = $clog2(HP_MAX + 1);
  localparam int FC_W = $clog2(FLASH_CYC + 1);
  typedef enum logic [1:0] {S_IDLE, S_ALIVE, S_FLASH} slot_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ALIVE} slot_state_t;
`endif

  slot_state_t      slot_st   [N_MON];
  slot_state_t      slot_st_n [N_MON];
  logic [9:0]       pos_x     [N_MON];
  logic [9:0]       pos_x_n   [N_MON];
  logic [9:0]       pos_y     [N_MON];
  logic [9:0]       pos_y_n   [N_MON];
  logic [N_MON-1:0] dir, dir_n;
  logic [13:0]      last_spawn, last_spawn_n;
  logic [7:0]       kill_cnt, kill_cnt_n;
  logic             blt_hit, blt_hit_n;
  logic             spawn_due, spawn_done, hit_done, kill_now, in_bullet, off_screen;
  logic             pix_found;
  logic [N_MON-1:0] alive_c;
`ifdef MON_HP_EN
  logic [HP_W-1:0]  hp     [N_MON];
  logic [HP_W-1:0]  hp_n   [N_MON];
  logic [FC_W-1:0]  fcnt   [N_MON];
  logic [FC_W-1:0]  fcnt_n [N_MON];
`endif

  // State register: all slot and bookkeeping state updates here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MON; i++) begin
        slot_st[i] <= S_IDLE;
        pos_x[i]   <= '0;
        pos_y[i]   <= '0;
`ifdef MON_HP_EN
        hp[i]      <= '0;
        fcnt[i]    <= '0;
`endif
      end
      dir        <= '0;
      last_spawn <= '0;
      kill_cnt   <= '0;
      blt_hit    <= 1'b0;
    end else begin
      for (int i = 0; i < N_MON; i++) begin
        slot_st[i] <= slot_st_n[i];
        pos_x[i]   <= pos_x_n[i];
        pos_y[i]   <= pos_y_n[i];
`ifdef MON_HP_EN
        hp[i]      <= hp_n[i];
        fcnt[i]    <= fcnt_n[i];
`endif
      end
      dir        <= dir_n;
      last_spawn <= last_spawn_n;
      kill_cnt   <= kill_cnt_n;
      blt_hit    <= blt_hit_n;
    end
  end

  // Next-state logic. spawn_done / hit_done make the scan pick only the
  // lowest-index candidate. Spawning looks at the registered state, so a
  // slot freed this clock can be refilled on the following one. The hit
  // overrides the off-screen retire so a simultaneous hit still counts.
  always_comb begin
    for (int i = 0; i < N_MON; i++) begin
      slot_st_n[i] = slot_st[i];
      pos_x_n[i]   = pos_x[i];
      pos_y_n[i]   = pos_y[i];
`ifdef MON_HP_EN
      hp_n[i]      = hp[i];
      fcnt_n[i]    = fcnt[i];
`endif
    end
    dir_n        = dir;
    last_spawn_n = last_spawn;
    kill_cnt_n   = kill_cnt;
    blt_hit_n    = 1'b0;
    spawn_done   = 1'b0;
    hit_done     = 1'b0;
    kill_now     = 1'b0;
    in_bullet    = 1'b0;
    off_screen   = 1'b0;
    spawn_due    = ({1'b0, bus.score} >= ({1'b0, last_spawn} + GAP15));

    if (bus.state != 2'd2) begin
      for (int i = 0; i < N_MON; i++) slot_st_n[i] = S_IDLE;
      last_spawn_n = bus.score;
    end else begin
      for (int i = 0; i < N_MON; i++) begin
        if (slot_st[i] == S_IDLE) begin
          if (spawn_due && !spawn_done) begin
            spawn_done   = 1'b1;
            slot_st_n[i] = S_ALIVE;
            pos_x_n[i]   = ({1'b0, bus.rand_x} > X_MAX) ? X_MAX : {1'b0, bus.rand_x};
            pos_y_n[i]   = '0;
            dir_n[i]     = 1'b0;
            last_spawn_n = bus.score;
`ifdef MON_HP_EN
            hp_n[i]      = HP_W'(HP_MAX);
            fcnt_n[i]    = '0;
`endif
          end
        end else begin
          if (!dir[i]) begin
            if (({1'b0, pos_x[i]} + W_PLUS_SP) <= RIGHT_LIM) pos_x_n[i] = pos_x[i] + SPD10;
            else dir_n[i] = 1'b1;
          end else begin
            if (pos_x[i] >= SPD10) pos_x_n[i] = pos_x[i] - SPD10;
            else dir_n[i] = 1'b0;
          end
          pos_y_n[i] = pos_y[i] + 10'(bus.adv);
          off_screen = (pos_y[i] >= MAP_H10);
`ifdef MON_HP_EN
          if (slot_st[i] == S_FLASH) begin
            if (fcnt[i] == FC_W'(FLASH_CYC - 1)) slot_st_n[i] = S_ALIVE;
            else fcnt_n[i] = fcnt[i] + FC_W'(1);
          end
`endif
          if (off_screen) slot_st_n[i] = S_IDLE;

          in_bullet = ({1'b0, pos_x[i]} <= {1'b0, bus.blt_x}) &&
                      ({1'b0, bus.blt_x} < ({1'b0, pos_x[i]} + MON_W11)) &&
                      ({1'b0, pos_y[i]} <= {1'b0, bus.blt_y}) &&
                      ({1'b0, bus.blt_y} < ({1'b0, pos_y[i]} + MON_H11));
          if (slot_st[i] == S_ALIVE && bus.blt_exist && in_bullet && !hit_done) begin
            hit_done  = 1'b1;
            blt_hit_n = 1'b1;
`ifdef MON_HP_EN
            hp_n[i] = hp[i] - HP_W'(1);
            if (hp[i] <= HP_W'(1) || off_screen) begin
              slot_st_n[i] = S_IDLE;
              kill_now     = 1'b1;
            end else begin
              slot_st_n[i] = S_FLASH;
              fcnt_n[i]    = '0;
            end
`else
            slot_st_n[i] = S_IDLE;
            kill_now     = 1'b1;
`endif
          end
        end
      end
      if (kill_now && kill_cnt != 8'hFF) kill_cnt_n = kill_cnt + 8'd1;
    end
  end

  // Output logic: live flags plus the combinational sprite lookup, where the
  // lowest-index live slot covering the scan position owns the pixel.
  always_comb begin
    pix_found      = 1'b0;
    bus.valid      = 1'b0;
    bus.pixel_addr = '0;
    for (int i = 0; i < N_MON; i++) begin
      alive_c[i] = (slot_st[i] != S_IDLE);
      if (!pix_found && slot_st[i] != S_IDLE &&
          ({1'b0, bus.h_cnt} >= {1'b0, pos_x[i]}) &&
          ({1'b0, bus.h_cnt} < ({1'b0, pos_x[i]} + MON_W11)) &&
          ({1'b0, bus.v_cnt} >= {1'b0, pos_y[i]}) &&
          ({1'b0, bus.v_cnt} < ({1'b0, pos_y[i]} + MON_H11))) begin
        pix_found      = 1'b1;
        bus.valid      = 1'b1;
        bus.pixel_addr = 17'(bus.h_cnt - pos_x[i]) + 17'(bus.v_cnt - pos_y[i]) * 17'(MON_W);
`ifdef MON_HP_EN
        // Blink: a flashing slot still owns the pixel but shows nothing.
        if (slot_st[i] == S_FLASH && fcnt[i][0]) begin
          bus.valid      = 1'b0;
          bus.pixel_addr = '0;
        end
`endif
      end
    end
  end

  assign bus.mon_alive = alive_c;
  assign bus.blt_hit   = blt_hit;
  assign bus.kill_cnt  = kill_cnt;

endmodule
